// File: rtl/cpu_pipe_pkg.sv
// Shared constants and helpers for the CPU pipeline register slices.
// Default geometry and the occupancy-counter width function live here.
package cpu_pipe_pkg;

   localparam int CPU_PIPE_WIDTH = 32;
   localparam int CPU_PIPE_DEPTH = 2;

   // Bits needed to count 0..depth valid stages inclusive.
   function automatic int occ_width(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/pipe_stage.sv
// One elastic pipeline slot: a data register plus valid bit with load and clear.
// Build option ELASTIC_PIPE_RESET_DATA_EN also zeroes the data on reset and clear.
module pipe_stage #(
   parameter int WIDTH = 32
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             i_load,
   input  logic             i_clear,
   input  logic             i_valid,
   input  logic [WIDTH-1:0] i_data,
   output logic             o_valid,
   output logic [WIDTH-1:0] o_data
);

   logic             r_valid;
   logic [WIDTH-1:0] r_data;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_valid <= 1'b0;
      end else if (i_clear) begin
         r_valid <= 1'b0;
      end else if (i_load) begin
         r_valid <= i_valid;
      end
   end

`ifdef ELASTIC_PIPE_RESET_DATA_EN
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_data <= '0;
      end else if (i_clear) begin
         r_data <= '0;
      end else if (i_load) begin
         r_data <= i_data;
      end
   end
`else
   // Data is qualified by r_valid, so it needs no reset.
   always_ff @(posedge clock) begin
      if (i_load) begin
         r_data <= i_data;
      end
   end
`endif

   assign o_valid = r_valid;
   assign o_data  = r_data;

endmodule

// File: rtl/elastic_pipe_reg.sv
// DEPTH-stage elastic pipeline register with bubble collapsing, flush and occupancy.
// Define ELASTIC_PIPE_RESET_DATA_EN to also clear data registers on reset/flush.
module elastic_pipe_reg
   import cpu_pipe_pkg::*;
#(
   parameter int WIDTH = CPU_PIPE_WIDTH,
   parameter int DEPTH = CPU_PIPE_DEPTH
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic                          flush,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [WIDTH-1:0]              in_data,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [WIDTH-1:0]              out_data,
   output logic [occ_width(DEPTH)-1:0]   occupancy
);

   localparam int                OCC_W   = occ_width(DEPTH);
   localparam logic [OCC_W-1:0]  OCC_ONE = OCC_W'(1);

   // Handshake: a transfer happens on a rising edge where valid && ready are
   // both high; valid never waits on ready, and flush suppresses both sides.
   logic [DEPTH-1:0] w_valid;
   logic [DEPTH-1:0] w_rdy;
   logic [WIDTH-1:0] w_data [DEPTH];
   logic             w_push;
   logic             w_pop;
   logic [OCC_W-1:0] r_occ;

   genvar i;
   generate
      for (i = 0; i < DEPTH; i++) begin : g_stage
         // Stage i can move iff some stage at or after it is empty, or the sink takes data.
         assign w_rdy[i] = out_ready || !(&w_valid[DEPTH-1:i]);

         if (i == 0) begin : g_head
            pipe_stage #(.WIDTH(WIDTH)) u_stage (
               .clock   (clock),
               .reset   (reset),
               .i_load  (w_rdy[i]),
               .i_clear (flush),
               .i_valid (w_push),
               .i_data  (in_data),
               .o_valid (w_valid[i]),
               .o_data  (w_data[i])
            );
         end else begin : g_body
            pipe_stage #(.WIDTH(WIDTH)) u_stage (
               .clock   (clock),
               .reset   (reset),
               .i_load  (w_rdy[i]),
               .i_clear (flush),
               .i_valid (w_valid[i-1]),
               .i_data  (w_data[i-1]),
               .o_valid (w_valid[i]),
               .o_data  (w_data[i])
            );
         end
      end
   endgenerate

   assign in_ready  = w_rdy[0] && !flush;
   assign out_valid = w_valid[DEPTH-1] && !flush;
   assign out_data  = w_data[DEPTH-1];
   assign w_push    = in_valid && in_ready;
   assign w_pop     = out_valid && out_ready;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_occ <= '0;
      end else if (flush) begin
         r_occ <= '0;
      end else if (w_push && !w_pop) begin
         r_occ <= r_occ + OCC_ONE;
      end else if (w_pop && !w_push) begin
         r_occ <= r_occ - OCC_ONE;
      end
   end

   assign occupancy = r_occ;

endmodule

// File: tb/tb_elastic_pipe_reg.sv
// Directed bench for elastic_pipe_reg: DEPTH=2/WIDTH=32 and DEPTH=4/WIDTH=6 instances.
module tb_elastic_pipe_reg;

   logic        clk = 1'b0;
   logic        rst = 1'b1;

   // instance A: defaults (WIDTH=32, DEPTH=2)
   logic        a_flush = 1'b0;
   logic        a_in_valid = 1'b0;
   logic        a_in_ready;
   logic [31:0] a_in_data = '0;
   logic        a_out_valid;
   logic        a_out_ready = 1'b1;
   logic [31:0] a_out_data;
   logic [1:0]  a_occ;

   // instance B: WIDTH=6, DEPTH=4
   logic        b_flush = 1'b0;
   logic        b_in_valid = 1'b0;
   logic        b_in_ready;
   logic [5:0]  b_in_data = '0;
   logic        b_out_valid;
   logic        b_out_ready = 1'b1;
   logic [5:0]  b_out_data;
   logic [2:0]  b_occ;

   int n_checks = 0;
   int n_pass   = 0;

   elastic_pipe_reg u_dut_a (
      .clock     (clk),
      .reset     (rst),
      .flush     (a_flush),
      .in_valid  (a_in_valid),
      .in_ready  (a_in_ready),
      .in_data   (a_in_data),
      .out_valid (a_out_valid),
      .out_ready (a_out_ready),
      .out_data  (a_out_data),
      .occupancy (a_occ)
   );

   elastic_pipe_reg #(.WIDTH(6), .DEPTH(4)) u_dut_b (
      .clock     (clk),
      .reset     (rst),
      .flush     (b_flush),
      .in_valid  (b_in_valid),
      .in_ready  (b_in_ready),
      .in_data   (b_in_data),
      .out_valid (b_out_valid),
      .out_ready (b_out_ready),
      .out_data  (b_out_data),
      .occupancy (b_occ)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Advance to just after the next rising edge; inputs change here.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Let combinational outputs settle before sampling.
   task automatic settle();
      #2;
   endtask

   task automatic fill_a(input logic [31:0] d0, input logic [31:0] d1);
      a_out_ready = 1'b0;
      a_in_valid  = 1'b1;
      a_in_data   = d0;
      step();
      a_in_data   = d1;
      step();
      a_in_valid  = 1'b0;
   endtask

   initial begin
      logic [5:0] b_vals [4];
      b_vals[0] = 6'h01; b_vals[1] = 6'h12; b_vals[2] = 6'h23; b_vals[3] = 6'h3C;

      // ---------------- reset ----------------
      #12;
      check_eq("rst_a_out_valid", 32'(a_out_valid), 32'd0);
      check_eq("rst_a_occ",       32'(a_occ),       32'd0);
      check_eq("rst_a_in_ready",  32'(a_in_ready),  32'd1);
      check_eq("rst_b_occ",       32'(b_occ),       32'd0);
      rst = 1'b0;
      step();

      // ---------------- streaming ----------------
      a_out_ready = 1'b1;
      a_in_valid  = 1'b1;
      a_in_data   = 32'hA;
      settle();
      check_eq("stream_in_ready", 32'(a_in_ready), 32'd1);
      check_eq("stream_c0_valid", 32'(a_out_valid), 32'd0);
      step();
      a_in_data = 32'h11;
      settle();
      check_eq("stream_c1_valid", 32'(a_out_valid), 32'd0);
      step();
      a_in_data = 32'h5E;
      settle();
      check_eq("stream_c2_valid", 32'(a_out_valid), 32'd1);
      check_eq("stream_c2_data",  a_out_data, 32'hA);
      check_eq("stream_c2_occ",   32'(a_occ), 32'd2);
      step();
      a_in_valid = 1'b0;
      settle();
      check_eq("stream_c3_data",  a_out_data, 32'h11);
      step();
      settle();
      check_eq("stream_c4_valid", 32'(a_out_valid), 32'd1);
      check_eq("stream_c4_data",  a_out_data, 32'h5E);
      check_eq("stream_c4_occ",   32'(a_occ), 32'd1);
      step();
      settle();
      check_eq("stream_c5_valid", 32'(a_out_valid), 32'd0);
      check_eq("stream_c5_occ",   32'(a_occ), 32'd0);
      step();

      // ---------------- backpressure ----------------
      a_out_ready = 1'b0;
      a_in_valid  = 1'b1;
      a_in_data   = 32'h1;
      step();
      a_in_data   = 32'h2;
      step();
      a_in_data   = 32'h3;
      settle();
      check_eq("bp_in_ready", 32'(a_in_ready), 32'd0);
      check_eq("bp_occ",      32'(a_occ), 32'd2);
      check_eq("bp_data",     a_out_data, 32'h1);
      step();
      settle();
      check_eq("bp_hold_valid", 32'(a_out_valid), 32'd1);
      check_eq("bp_hold_data",  a_out_data, 32'h1);
      check_eq("bp_hold_ready", 32'(a_in_ready), 32'd0);
      a_out_ready = 1'b1;
      settle();
      check_eq("bp_release_ready", 32'(a_in_ready), 32'd1);
      check_eq("bp_release_data",  a_out_data, 32'h1);
      step();
      a_in_valid = 1'b0;
      settle();
      check_eq("bp_out2_data", a_out_data, 32'h2);
      check_eq("bp_out2_occ",  32'(a_occ), 32'd2);
      step();
      settle();
      check_eq("bp_out3_data", a_out_data, 32'h3);
      step();
      settle();
      check_eq("bp_empty_valid", 32'(a_out_valid), 32'd0);
      check_eq("bp_empty_occ",   32'(a_occ), 32'd0);

      // ---------------- full pass-through ----------------
      fill_a(32'h21, 32'h22);
      check_eq("full_occ", 32'(a_occ), 32'd2);
      a_out_ready = 1'b1;
      a_in_valid  = 1'b1;
      a_in_data   = 32'h7;
      settle();
      check_eq("full_in_ready", 32'(a_in_ready), 32'd1);
      check_eq("full_data0",    a_out_data, 32'h21);
      step();
      a_in_valid = 1'b0;
      settle();
      check_eq("full_data1", a_out_data, 32'h22);
      check_eq("full_occ1",  32'(a_occ), 32'd2);
      step();
      settle();
      check_eq("full_data7",  a_out_data, 32'h7);
      check_eq("full_valid7", 32'(a_out_valid), 32'd1);
      step();
      settle();
      check_eq("full_empty", 32'(a_out_valid), 32'd0);

      // ---------------- flush ----------------
      fill_a(32'h31, 32'h32);
      a_out_ready = 1'b1;
      a_flush     = 1'b1;
      a_in_valid  = 1'b1;
      a_in_data   = 32'hFF;
      settle();
      check_eq("flush_in_ready",  32'(a_in_ready), 32'd0);
      check_eq("flush_out_valid", 32'(a_out_valid), 32'd0);
      step();
      a_flush    = 1'b0;
      a_in_valid = 1'b0;
      settle();
      check_eq("flush_occ",    32'(a_occ), 32'd0);
      check_eq("flush_valid0", 32'(a_out_valid), 32'd0);
      step();
      settle();
      check_eq("flush_valid1", 32'(a_out_valid), 32'd0);
      step();
      settle();
      check_eq("flush_valid2", 32'(a_out_valid), 32'd0);

      // ---------------- asynchronous reset ----------------
      fill_a(32'h41, 32'h42);
      check_eq("arst_pre_occ", 32'(a_occ), 32'd2);
      #2;
      rst = 1'b1;
      #1;
      check_eq("arst_out_valid", 32'(a_out_valid), 32'd0);
      check_eq("arst_occ",       32'(a_occ), 32'd0);
      check_eq("arst_in_ready",  32'(a_in_ready), 32'd1);
`ifdef ELASTIC_PIPE_RESET_DATA_EN
      check_eq("arst_data", a_out_data, 32'h0);
`endif
      step();
      rst = 1'b0;
      step();
      a_out_ready = 1'b1;
      a_in_valid  = 1'b1;
      a_in_data   = 32'h55;
      step();
      a_in_valid = 1'b0;
      settle();
      check_eq("arst_lat_c1", 32'(a_out_valid), 32'd0);
      step();
      settle();
      check_eq("arst_lat_c2_valid", 32'(a_out_valid), 32'd1);
      check_eq("arst_lat_c2_data",  a_out_data, 32'h55);
      step();

      // ---------------- parametric WIDTH=6 DEPTH=4 ----------------
      b_out_ready = 1'b1;
      b_in_valid  = 1'b1;
      b_in_data   = 6'h2A;
      step();
      b_in_valid = 1'b0;
      for (int c = 1; c < 4; c++) begin
         settle();
         check_eq($sformatf("b_lat_c%0d", c), 32'(b_out_valid), 32'd0);
         step();
      end
      settle();
      check_eq("b_lat_c4_valid", 32'(b_out_valid), 32'd1);
      check_eq("b_lat_c4_data",  32'(b_out_data), 32'h2A);
      step();
      settle();
      check_eq("b_lat_empty", 32'(b_occ), 32'd0);

      b_out_ready = 1'b0;
      b_in_valid  = 1'b1;
      for (int k = 0; k < 4; k++) begin
         b_in_data = b_vals[k];
         settle();
         check_eq($sformatf("b_fill_ready%0d", k), 32'(b_in_ready), 32'd1);
         step();
      end
      b_in_data = 6'h3F;
      settle();
      check_eq("b_full_occ",   32'(b_occ), 32'd4);
      check_eq("b_full_ready", 32'(b_in_ready), 32'd0);
      b_in_valid  = 1'b0;
      b_out_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         settle();
         check_eq($sformatf("b_drain_data%0d", k), 32'(b_out_data), 32'(b_vals[k]));
         check_eq($sformatf("b_drain_valid%0d", k), 32'(b_out_valid), 32'd1);
         step();
      end
      settle();
      check_eq("b_drained_valid", 32'(b_out_valid), 32'd0);
      check_eq("b_drained_occ",   32'(b_occ), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
